// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared defaults and state encoding for the FC accumulate/argmax stage
package fc_pkg;

  localparam int DEF_LENGTH_FC  = 64;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_CLASS  = 4;
  localparam int DEF_ACC_WIDTH  = 2*DEF_DATA_WIDTH + $clog2(DEF_LENGTH_FC);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } fc_state_t;

  // Counter width that stays legal when a count of one collapses $clog2 to zero.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_argmax_tracker.sv
// rtl/fc_argmax_tracker.sv - running maximum over class sums within one frame
module fc_argmax_tracker
  import fc_pkg::*;
#(
  parameter int IW        = 2,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 upd,
  input  logic [IW-1:0]        upd_idx,
  input  logic [ACC_WIDTH-1:0] upd_score,
  input  logic                 frame_end,
  output logic [IW-1:0]        win_idx,
  output logic [ACC_WIDTH-1:0] win_score
);

  logic [IW-1:0]        best_idx;
  logic [ACC_WIDTH-1:0] best_score;
  logic                 take_new;

  // Class 0 seeds the frame; later classes must be strictly larger so ties keep the lower index.
  always_comb begin
    take_new  = (upd_idx == '0) || ($signed(upd_score) > $signed(best_score));
    win_idx   = take_new ? upd_idx   : best_idx;
    win_score = take_new ? upd_score : best_score;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_idx   <= '0;
      best_score <= '0;
    end else if (clear) begin
      best_idx   <= '0;
      best_score <= '0;
    end else if (upd) begin
      if (frame_end) begin
        best_idx   <= '0;
        best_score <= '0;
      end else begin
        best_idx   <= win_idx;
        best_score <= win_score;
      end
    end
  end

endmodule

// File: rtl/fc_accum_argmax.sv
// rtl/fc_accum_argmax.sv - per-class accumulation of FC outputs with frame argmax result
module fc_accum_argmax
  import fc_pkg::*;
#(
  parameter int LENGTH_FC  = DEF_LENGTH_FC,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CLASS  = DEF_NUM_CLASS,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(LENGTH_FC)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [2*DATA_WIDTH-1:0]      in_data,
  input  logic                         clear,
  input  logic                         class_ack,
  output logic                         score_valid,
  output logic [ACC_WIDTH-1:0]         score,
  output logic [$clog2(NUM_CLASS)-1:0] score_idx,
  output logic                         class_valid,
  output logic [$clog2(NUM_CLASS)-1:0] class_id,
  output logic [ACC_WIDTH-1:0]         class_score,
  output logic                         busy,
  output logic                         overrun
);

  localparam int IW = $clog2(NUM_CLASS);
  localparam int EW = cnt_width(LENGTH_FC);

  fc_state_t            state, state_next;
  logic [EW-1:0]        elem_cnt;
  logic [IW-1:0]        class_cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 take;
  logic                 last_elem;
  logic                 last_class;
  logic                 class_done;
  logic                 frame_done;
  logic [IW-1:0]        win_idx;
  logic [ACC_WIDTH-1:0] win_score;

  // A sample presented together with clear is dropped.
  always_comb begin
    take       = in_valid && !clear;
    sample_ext = ACC_WIDTH'($signed(in_data));
    sum        = acc + sample_ext;
    last_elem  = (elem_cnt == EW'(LENGTH_FC-1));
    last_class = (class_cnt == IW'(NUM_CLASS-1));
    class_done = take && last_elem;
    frame_done = class_done && last_class;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (take) state_next = frame_done ? ST_IDLE : ST_ACCUM;
      ST_ACCUM: if (clear || frame_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt    <= '0;
      class_cnt   <= '0;
      acc         <= '0;
      score_valid <= 1'b0;
      score       <= '0;
      score_idx   <= '0;
      class_valid <= 1'b0;
      class_id    <= '0;
      class_score <= '0;
      overrun     <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      overrun     <= 1'b0;
      if (class_ack) class_valid <= 1'b0;
      if (clear) begin
        elem_cnt  <= '0;
        class_cnt <= '0;
        acc       <= '0;
      end else if (in_valid) begin
        if (last_elem) begin
          acc         <= '0;
          elem_cnt    <= '0;
          score_valid <= 1'b1;
          score       <= sum;
          score_idx   <= class_cnt;
          class_cnt   <= last_class ? '0 : class_cnt + IW'(1);
          // A new result overwrites a pending one; it is only lost if not acknowledged now.
          if (last_class) begin
            class_valid <= 1'b1;
            class_id    <= win_idx;
            class_score <= win_score;
            overrun     <= class_valid && !class_ack;
          end
        end else begin
          acc      <= sum;
          elem_cnt <= elem_cnt + EW'(1);
        end
      end
    end
  end

  fc_argmax_tracker #(
    .IW        (IW),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .upd       (class_done),
    .upd_idx   (class_cnt),
    .upd_score (sum),
    .frame_end (frame_done),
    .win_idx   (win_idx),
    .win_score (win_score)
  );

endmodule
